// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: steers bytes onto a req/ack data bus, formats loads,
// and holds the pipeline in a stall while an access is outstanding.
//
// state | meaning
// IDLE  | no access in flight; issues aligned loads/stores, flags misaligned ones
// WAIT  | request on the bus, waiting for dmem_ack or the timeout
// DONE  | one stall-free cycle so MA_WB captures MEMOutM; never issues
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [1:0]  size_m,
  input  logic        sign_ext_m,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] store_data_m,
  output logic [31:0] MEMOutM,
  output logic        stall_m,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      memout_q, memout_d;
  logic             bus_err_q, bus_err_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;

  logic        access;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        issue;
  logic        timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  assign access     = valid_m & (mem_read_m | mem_write_m);
  assign is_half    = (size_m == 2'b01);
  assign is_word    = size_m[1];
  assign misaligned = (is_half & ALUOutM[0]) | (is_word & (ALUOutM[1:0] != 2'b00));
  assign issue      = (state_q == ST_IDLE) & access & ~misaligned;
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Byte-lane steering of the outgoing request
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = store_data_m;
    case (size_m)
      2'b00: begin
        be_calc    = 4'b0001 << ALUOutM[1:0];
        wdata_calc = {4{store_data_m[7:0]}};
      end
      2'b01: begin
        be_calc    = ALUOutM[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{store_data_m[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = store_data_m;
      end
    endcase
  end

  // Load formatting uses the lane/size captured at issue, not the live inputs
  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (lane_q)
      2'b00:   byte_sel = dmem_rdata[7:0];
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_fmt = dmem_rdata;
    case (size_q)
      2'b00:   load_fmt = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      2'b01:   load_fmt = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access && !misaligned) state_d = ST_WAIT;
      ST_WAIT: if (dmem_ack || timeout)   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_m  = 1'b0;
    addr_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_m  = access & ~misaligned;
        addr_err = access & misaligned;
      end
      ST_WAIT: stall_m = 1'b1;
      default: begin
        stall_m  = 1'b0;
        addr_err = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    memout_d  = memout_q;
    bus_err_d = bus_err_q;
    lane_d    = lane_q;
    size_d    = size_q;
    sext_d    = sext_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          req_d     = 1'b1;
          we_d      = mem_write_m;
          addr_d    = {ALUOutM[31:2], 2'b00};
          be_d      = be_calc;
          wdata_d   = wdata_calc;
          lane_d    = ALUOutM[1:0];
          size_d    = size_m;
          sext_d    = sign_ext_m;
          cnt_d     = '0;
          bus_err_d = 1'b0;
        end
      end
      ST_WAIT: begin
        // A late ack on the final cycle still wins over the timeout
        if (dmem_ack) begin
          req_d = 1'b0;
          if (!we_q) memout_d = load_fmt;
        end else if (timeout) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          memout_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      memout_q  <= '0;
      bus_err_q <= 1'b0;
      lane_q    <= '0;
      size_q    <= '0;
      sext_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      memout_q  <= memout_d;
      bus_err_q <= bus_err_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign MEMOutM    = memout_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset/idle-ack sequences,
// then random accesses checked against an arithmetic reference model.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, mem_read_m, mem_write_m, sign_ext_m;
  logic [1:0]  size_m;
  logic [31:0] ALUOutM, store_data_m;
  logic [31:0] MEMOutM;
  logic        stall_m, addr_err, bus_err;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .valid_m(valid_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .size_m(size_m), .sign_ext_m(sign_ext_m),
    .ALUOutM(ALUOutM), .store_data_m(store_data_m),
    .MEMOutM(MEMOutM), .stall_m(stall_m), .addr_err(addr_err), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] sd;
    int          ack_wait;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_mem;
    int          exp_stall;
    logic        exp_ae;
    logic        exp_berr;
  } vec_t;

  typedef struct {
    int          stall;
    logic        ae;
    logic        req_seen;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] addr;
    logic [31:0] mem;
    logic        berr;
    logic        stable;
    logic        bound_hit;
  } obs_t;

  // Reference model: plain arithmetic from the lane rules
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'd0) return (sd % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] a, input logic [31:0] rdata);
    int off;
    logic [31:0] v;
    off = int'(a % 4);
    if (sz == 2'd0) begin
      v = (rdata >> (8 * off)) % 256;
      if (sx && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = (rdata >> (8 * ((off / 2) * 2))) % 65536;
      if (sx && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rdata;
  endfunction

  function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Runs one MA instruction starting at a negedge; acks after ack_wait WAIT cycles (-1: never)
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                            input logic [31:0] addr, input logic [31:0] sd, input int ack_wait,
                            input logic [31:0] rdata, output obs_t o);
    int cyc;
    int waits;
    bit fin;
    bit first_req;
    o.stall = 0; o.ae = 1'b0; o.req_seen = 1'b0; o.be = '0; o.wdata = '0; o.we = 1'b0;
    o.addr = '0; o.mem = '0; o.berr = 1'b0; o.stable = 1'b1; o.bound_hit = 1'b0;
    valid_m = 1'b1; mem_read_m = rd; mem_write_m = wr; size_m = sz; sign_ext_m = sx;
    ALUOutM = addr; store_data_m = sd; dmem_rdata = rdata; dmem_ack = 1'b0;
    cyc = 0; waits = 0; fin = 1'b0; first_req = 1'b1;
    while (!fin && cyc < 60) begin
      #1;
      if (stall_m) o.stall++;
      if (cyc == 0) o.ae = addr_err;
      if (dmem_req) begin
        o.req_seen = 1'b1;
        if (first_req) begin
          o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we; o.addr = dmem_addr;
          first_req = 1'b0;
        end else if (o.be !== dmem_be || o.wdata !== dmem_wdata || o.we !== dmem_we ||
                     o.addr !== dmem_addr) begin
          o.stable = 1'b0;
        end
        dmem_ack = (waits == ack_wait);
        waits++;
      end else begin
        dmem_ack = 1'b0;
        if (!stall_m) begin
          o.mem = MEMOutM; o.berr = bus_err; fin = 1'b1;
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) o.bound_hit = 1'b1;
    @(posedge clk);
    #1;
    if (dmem_req) o.req_seen = 1'b1;
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
  endtask

  vec_t tbl[14];
  obs_t o;
  logic [31:0] mdl_mem;
  logic        mdl_berr;

  task automatic check_obs(input string tag, input obs_t ob, input logic wr, input logic [31:0] addr,
                           input logic ae, input int stall, input logic [31:0] mem, input logic berr,
                           input logic [3:0] be, input logic [31:0] wdata);
    chk({tag, ".bound"}, 32'(ob.bound_hit), 32'd0);
    chk({tag, ".stall_cycles"}, 32'(ob.stall), 32'(stall));
    chk({tag, ".addr_err"}, 32'(ob.ae), 32'(ae));
    chk({tag, ".MEMOutM"}, ob.mem, mem);
    chk({tag, ".bus_err"}, 32'(ob.berr), 32'(berr));
    if (ae) begin
      chk({tag, ".req_absent"}, 32'(ob.req_seen), 32'd0);
    end else begin
      chk({tag, ".be"}, 32'(ob.be), 32'(be));
      chk({tag, ".addr"}, ob.addr, addr & 32'hFFFF_FFFC);
      chk({tag, ".we"}, 32'(ob.we), 32'(wr));
      chk({tag, ".stable"}, 32'(ob.stable), 32'd1);
      if (wr) chk({tag, ".wdata"}, ob.wdata, wdata);
    end
  endtask

  initial begin
    rst = 1'b0;
    valid_m = 0; mem_read_m = 0; mem_write_m = 0; size_m = 0; sign_ext_m = 0;
    ALUOutM = 0; store_data_m = 0; dmem_ack = 0; dmem_rdata = 0;

    //      rd wr sz  sx  addr          sd            ack  rdata         be     wdata         mem           stall ae berr
    tbl[0]  = '{1, 0, 2'd2, 0, 32'h0000_1004, 32'h0,        0, 32'h8899_AABB, 4'hF, 32'h0,        32'h8899_AABB, 2,  0, 0};
    tbl[1]  = '{1, 0, 2'd0, 1, 32'h0000_1003, 32'h0,        0, 32'h8011_2233, 4'h8, 32'h0,        32'hFFFF_FF80, 2,  0, 0};
    tbl[2]  = '{1, 0, 2'd0, 0, 32'h0000_1003, 32'h0,        0, 32'h8011_2233, 4'h8, 32'h0,        32'h0000_0080, 2,  0, 0};
    tbl[3]  = '{0, 1, 2'd1, 0, 32'h0000_2002, 32'h0000_BEEF, 3, 32'h0,        4'hC, 32'hBEEF_BEEF, 32'h0000_0080, 5,  0, 0};
    tbl[4]  = '{1, 0, 2'd2, 0, 32'h0000_1002, 32'h0,        0, 32'h0,         4'h0, 32'h0,        32'h0000_0080, 0,  1, 0};
    tbl[5]  = '{1, 0, 2'd2, 0, 32'h0000_3000, 32'h0,       -1, 32'h5555_5555, 4'hF, 32'h0,        32'h0,         17, 0, 1};
    tbl[6]  = '{1, 0, 2'd1, 0, 32'h0000_3001, 32'h0,        0, 32'h0,         4'h0, 32'h0,        32'h0,         0,  1, 1};
    tbl[7]  = '{1, 0, 2'd1, 1, 32'h0000_3002, 32'h0,        0, 32'h8001_7FFF, 4'hC, 32'h0,        32'hFFFF_8001, 2,  0, 0};
    tbl[8]  = '{0, 1, 2'd0, 0, 32'h0000_4001, 32'h1234_56A5, 1, 32'h0,        4'h2, 32'hA5A5_A5A5, 32'hFFFF_8001, 3,  0, 0};
    tbl[9]  = '{1, 0, 2'd2, 0, 32'h0000_5000, 32'h0,       15, 32'hCAFE_F00D, 4'hF, 32'h0,        32'hCAFE_F00D, 17, 0, 0};
    tbl[10] = '{1, 0, 2'd1, 0, 32'h0000_5000, 32'h0,        0, 32'h1234_F00D, 4'h3, 32'h0,        32'h0000_F00D, 2,  0, 0};
    tbl[11] = '{0, 1, 2'd3, 0, 32'h0000_6004, 32'hDEAD_BEEF, 0, 32'h0,        4'hF, 32'hDEAD_BEEF, 32'h0000_F00D, 2,  0, 0};
    tbl[12] = '{1, 0, 2'd2, 0, 32'h0000_7000, 32'h0,       16, 32'h1111_1111, 4'hF, 32'h0,        32'h0,         17, 0, 1};
    tbl[13] = '{1, 0, 2'd0, 1, 32'h0000_7002, 32'h0,        0, 32'h007F_0000, 4'h4, 32'h0,        32'h0000_007F, 2,  0, 0};

    repeat (2) @(negedge clk);
    chk("reset.dmem_req", 32'(dmem_req), 32'd0);
    chk("reset.dmem_we", 32'(dmem_we), 32'd0);
    chk("reset.dmem_addr", dmem_addr, 32'd0);
    chk("reset.dmem_be", 32'(dmem_be), 32'd0);
    chk("reset.dmem_wdata", dmem_wdata, 32'd0);
    chk("reset.MEMOutM", MEMOutM, 32'd0);
    chk("reset.bus_err", 32'(bus_err), 32'd0);
    chk("reset.stall_m", 32'(stall_m), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_access(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].addr, tbl[i].sd,
                 tbl[i].ack_wait, tbl[i].rdata, o);
      check_obs($sformatf("vec%0d", i), o, tbl[i].wr, tbl[i].addr, tbl[i].exp_ae,
                tbl[i].exp_stall, tbl[i].exp_mem, tbl[i].exp_berr, tbl[i].exp_be,
                tbl[i].exp_wdata);
    end

    // Stray ack while idle must not disturb anything
    begin
      bit quiet;
      quiet = 1'b1;
      dmem_ack = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      repeat (3) begin
        #1;
        if (dmem_req || stall_m) quiet = 1'b0;
        @(negedge clk);
      end
      dmem_ack = 1'b0;
      chk("idle_ack.quiet", 32'(quiet), 32'd1);
      chk("idle_ack.MEMOutM", MEMOutM, tbl[13].exp_mem);
    end

    // Asynchronous reset in the middle of WAIT
    valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; size_m = 2'd2;
    ALUOutM = 32'h0000_8000; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wait.req_before", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_wait.dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wait.MEMOutM", MEMOutM, 32'd0);
    valid_m = 1'b0; mem_read_m = 1'b0;
    #1;
    chk("rst_wait.idle", 32'(stall_m), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mdl_mem = 32'd0;
    mdl_berr = 1'b0;

    for (int n = 0; n < 250; n++) begin
      logic        rd, sx, mis, e_ae;
      logic [1:0]  sz;
      logic [31:0] addr, sd, rdata;
      int          aw, e_stall;
      rd = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4)));
      sd = $urandom;
      rdata = $urandom;
      if ($urandom_range(0, 9) == 0) aw = $urandom_range(15, 20);
      else aw = $urandom_range(0, 5);
      mis = m_misaligned(sz, addr);
      e_ae = mis;
      if (mis) begin
        e_stall = 0;
      end else begin
        mdl_berr = 1'b0;
        if (aw < TO) begin
          e_stall = aw + 2;
          if (rd) mdl_mem = m_load(sz, sx, addr, rdata);
        end else begin
          e_stall = TO + 1;
          mdl_berr = 1'b1;
          mdl_mem = 32'd0;
        end
      end
      run_access(rd, !rd, sz, sx, addr, sd, aw, rdata, o);
      check_obs($sformatf("rnd%0d", n), o, !rd, addr, e_ae, e_stall, mdl_mem, mdl_berr,
                m_be(sz, addr), m_wdata(sz, sd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
